// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encoding and pipeline depth.
// Optional flag outputs of the top level are enabled with BARREL_SHIFTER_FLAGS_EN.
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_ROT  = 2'b00,
        OP_LSH  = 2'b01,
        OP_ASH  = 2'b10,
        OP_PASS = 2'b11
    } op_t;

    // Number of register stages: one register after every pipe_every mux levels.
    function automatic int calc_lat(input int width, input int pipe_every);
        int levels;
        levels = $clog2(width);
        return (levels + pipe_every - 1) / pipe_every;
    endfunction

endpackage

// File: rtl/barrel_level.sv
// One combinational mux level of the barrel shifter: rotates, zero-fills or
// sign-fills by DIST positions in either direction when en_i is set.
module barrel_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  op_t              op_i,
    input  logic             left_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] shl_s;
    logic [WIDTH-1:0] shr_s;
    logic [WIDTH-1:0] fill_s;

    // Select the shifted, rotated or unchanged word for this level
    always_comb begin
        shl_s  = data_i << DIST;
        shr_s  = data_i >> DIST;
        fill_s = ~(ONES >> DIST);
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_ROT:  data_o = left_i ? (shl_s | (data_i >> (WIDTH - DIST)))
                                         : (shr_s | (data_i << (WIDTH - DIST)));
                OP_LSH:  data_o = left_i ? shl_s : shr_s;
                OP_ASH:  data_o = left_i ? shl_s : (sign_i ? (shr_s | fill_s) : shr_s);
                OP_PASS: data_o = data_i;
                default: data_o = data_i;
            endcase
        end else begin
            data_o = data_i;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate/shift unit with valid/ready on every stage; out_ready reaches
// in_ready combinationally. Define BARREL_SHIFTER_FLAGS_EN to add out_zero/out_carry.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int PIPE_EVERY = 2,
    localparam int SHAMT_W    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic               in_left,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
`ifdef BARREL_SHIFTER_FLAGS_EN
    ,
    output logic               out_zero,
    output logic               out_carry
`endif
);

    localparam int LEVELS = SHAMT_W;
    localparam int LAT    = calc_lat(WIDTH, PIPE_EVERY);

    typedef struct packed {
        logic [SHAMT_W-1:0] shamt;
        op_t                op;
        logic               left;
        logic               sign;
`ifdef BARREL_SHIFTER_FLAGS_EN
        logic               carry;
`endif
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = ctrl_t'({$bits(ctrl_t){1'b0}});

    logic [LAT:0]     ready_s;
    logic [LAT-1:0]   valid_s;
    logic             src_valid_s [LAT];
    logic [WIDTH-1:0] src_data_s  [LAT];
    ctrl_t            src_ctrl_s  [LAT];
    logic [WIDTH-1:0] lvl_out_s   [LEVELS];
    ctrl_t            in_ctrl_s;

    assign ready_s[LAT]   = out_ready;
    assign in_ready       = ready_s[0];
    assign src_valid_s[0] = in_valid;
    assign src_data_s[0]  = in_data;
    assign src_ctrl_s[0]  = in_ctrl_s;

`ifdef BARREL_SHIFTER_FLAGS_EN
    logic [SHAMT_W-1:0] neg_shamt_s;
    logic [SHAMT_W-1:0] dec_shamt_s;
    assign neg_shamt_s = {SHAMT_W{1'b0}} - in_shamt;
    assign dec_shamt_s = in_shamt - {{(SHAMT_W-1){1'b0}}, 1'b1};
`endif

    // Capture the control word; the sign bit is the operand MSB at accept time
    always_comb begin
        in_ctrl_s       = CTRL_ZERO;
        in_ctrl_s.shamt = in_shamt;
        in_ctrl_s.op    = op_t'(in_op);
        in_ctrl_s.left  = in_left;
        in_ctrl_s.sign  = in_data[WIDTH-1];
`ifdef BARREL_SHIFTER_FLAGS_EN
        // Last bit shifted out of the original operand
        if ((op_t'(in_op) != OP_PASS) && (in_shamt != {SHAMT_W{1'b0}})) begin
            if (in_left) begin
                in_ctrl_s.carry = in_data[neg_shamt_s];
            end else begin
                in_ctrl_s.carry = in_data[dec_shamt_s];
            end
        end else begin
            in_ctrl_s.carry = 1'b0;
        end
`endif
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int S = k / PIPE_EVERY;
        logic [WIDTH-1:0] lvl_in_s;
        if ((k % PIPE_EVERY) == 0) begin : g_first
            assign lvl_in_s = src_data_s[S];
        end else begin : g_chain
            assign lvl_in_s = lvl_out_s[k-1];
        end
        barrel_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .data_i (lvl_in_s),
            .en_i   (src_ctrl_s[S].shamt[k]),
            .op_i   (src_ctrl_s[S].op),
            .left_i (src_ctrl_s[S].left),
            .sign_i (src_ctrl_s[S].sign),
            .data_o (lvl_out_s[k])
        );
    end

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int LAST_LVL = (((s + 1) * PIPE_EVERY) > LEVELS) ? (LEVELS - 1)
                                                                    : ((s + 1) * PIPE_EVERY - 1);
        localparam bit IS_LAST  = (s == (LAT - 1));

        logic             valid_q;
        logic             valid_d;
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;

        assign ready_s[s] = !valid_q || ready_s[s+1];
        assign valid_s[s] = valid_q;

        // Load on ready; the output stage zeroes its data when it takes a bubble
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (ready_s[s]) begin
                valid_d = src_valid_s[s];
                if (src_valid_s[s]) begin
                    data_d = lvl_out_s[LAST_LVL];
                end else if (IS_LAST) begin
                    data_d = {WIDTH{1'b0}};
                end else begin
                    data_d = data_q;
                end
            end else begin
                valid_d = valid_q;
                data_d  = data_q;
            end
        end

        // Stage valid and data registers
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= {WIDTH{1'b0}};
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        if (!IS_LAST) begin : g_ctrl
            ctrl_t ctrl_q;
            ctrl_t ctrl_d;

            // Control travels with its data word
            always_comb begin
                ctrl_d = ctrl_q;
                if (ready_s[s] && src_valid_s[s]) begin
                    ctrl_d = src_ctrl_s[s];
                end else begin
                    ctrl_d = ctrl_q;
                end
            end

            // Stage control register
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctrl_q <= CTRL_ZERO;
                end else begin
                    ctrl_q <= ctrl_d;
                end
            end

            assign src_valid_s[s+1] = valid_q;
            assign src_data_s[s+1]  = data_q;
            assign src_ctrl_s[s+1]  = ctrl_q;
        end else begin : g_out
            assign out_valid = valid_q;
            assign out_data  = data_q;
`ifdef BARREL_SHIFTER_FLAGS_EN
            logic zero_q;
            logic zero_d;
            logic carry_q;
            logic carry_d;

            // Flags follow the output word and read 0 while no result is held
            always_comb begin
                zero_d  = valid_d && (data_d == {WIDTH{1'b0}});
                carry_d = carry_q;
                if (ready_s[s]) begin
                    carry_d = src_valid_s[s] ? src_ctrl_s[s].carry : 1'b0;
                end else begin
                    carry_d = carry_q;
                end
            end

            // Flag registers
            always_ff @(posedge clk) begin
                if (rst) begin
                    zero_q  <= 1'b0;
                    carry_q <= 1'b0;
                end else begin
                    zero_q  <= zero_d;
                    carry_q <= carry_d;
                end
            end

            assign out_zero  = zero_q;
            assign out_carry = carry_q;
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and swept bench for pipelined_barrel_shifter (WIDTH=16, PIPE_EVERY=2).
// Flag checks are included when BARREL_SHIFTER_FLAGS_EN is defined.
module tb_pipelined_barrel_shifter;

    localparam int W  = 16;
    localparam int SW = 4;

    typedef struct {
        logic [W-1:0] data;
        logic         zero;
        logic         carry;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = 16'h0000;
    logic [SW-1:0] in_shamt = 4'h0;
    logic [1:0]    in_op = 2'b00;
    logic          in_left = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
`ifdef BARREL_SHIFTER_FLAGS_EN
    logic          out_zero;
    logic          out_carry;
`endif

    int   errors = 0;
    int   checks = 0;
    int   stall_cycles = 0;
    bit   sweep_done = 1'b0;
    exp_t exp_q[$];

    pipelined_barrel_shifter #(.WIDTH(W), .PIPE_EVERY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_left   (in_left),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BARREL_SHIFTER_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_carry (out_carry)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int k,
                                               input logic [1:0] op, input logic l);
        if (op == 2'b11 || k == 0) return d;
        case (op)
            2'b00:   return l ? ((d << k) | (d >> (W - k))) : ((d >> k) | (d << (W - k)));
            2'b01:   return l ? (d << k) : (d >> k);
            default: return l ? (d << k) : W'($signed(d) >>> k);
        endcase
    endfunction

    function automatic logic ref_carry(input logic [W-1:0] d, input int k,
                                       input logic [1:0] op, input logic l);
        if (op == 2'b11 || k == 0) return 1'b0;
        return l ? d[W-k] : d[k-1];
    endfunction

    function automatic exp_t mk_exp(input logic [W-1:0] d, input int k, input logic [1:0] op,
                                    input logic l, input logic [W-1:0] want);
        exp_t e;
        e.data  = want;
        e.zero  = (want == 16'h0000);
        e.carry = ref_carry(d, k, op, l);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] d, input int k, input logic [1:0] op,
                        input logic l, input exp_t e);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = SW'(k);
        in_op    = op;
        in_left  = l;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
            stall_cycles++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake on the output must match the oldest expected beat
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
`ifdef BARREL_SHIFTER_FLAGS_EN
                check("out_zero", 32'(out_zero), 32'(e.zero));
                check("out_carry", 32'(out_carry), 32'(e.carry));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);

        // Latency: result visible one edge after the accepting edge (two register stages)
        send(16'h8001, 1, 2'b00, 1'b1, mk_exp(16'h8001, 1, 2'b00, 1'b1, 16'h0003));
        check("lat_not_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h0003);
        drain("drain_lat");

        send(16'h1234, 8,  2'b00, 1'b0, mk_exp(16'h1234, 8,  2'b00, 1'b0, 16'h3412));
        send(16'h1234, 8,  2'b00, 1'b1, mk_exp(16'h1234, 8,  2'b00, 1'b1, 16'h3412));
        send(16'h8000, 4,  2'b10, 1'b0, mk_exp(16'h8000, 4,  2'b10, 1'b0, 16'hF800));
        send(16'h8000, 4,  2'b01, 1'b0, mk_exp(16'h8000, 4,  2'b01, 1'b0, 16'h0800));
        send(16'h00FF, 12, 2'b01, 1'b1, mk_exp(16'h00FF, 12, 2'b01, 1'b1, 16'hF000));
        send(16'hBEEF, 5,  2'b11, 1'b1, mk_exp(16'hBEEF, 5,  2'b11, 1'b1, 16'hBEEF));
        send(16'h8000, 4,  2'b10, 1'b1, mk_exp(16'h8000, 4,  2'b10, 1'b1, 16'h0000));
        drain("drain_directed");

        // Back-pressure: two beats fill the pipe, the next two wait for release
        out_ready = 1'b0;
        send(16'h1111, 1, 2'b01, 1'b1, mk_exp(16'h1111, 1, 2'b01, 1'b1, 16'h2222));
        send(16'h00F0, 4, 2'b01, 1'b0, mk_exp(16'h00F0, 4, 2'b01, 1'b0, 16'h000F));
        fork
            begin
                send(16'hC001, 1, 2'b00, 1'b0, mk_exp(16'hC001, 1, 2'b00, 1'b0, 16'hE000));
                send(16'h0F00, 8, 2'b10, 1'b1, mk_exp(16'h0F00, 8, 2'b10, 1'b1, 16'h0000));
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 32'(in_ready), 32'd0);
                    check("bp_hold_data", 32'(out_data), 32'h2222);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_bp");

        // Full throughput with out_ready held high
        stall_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            send(d, i, 2'b01, 1'b1, mk_exp(d, i, 2'b01, 1'b1, ref_shift(d, i, 2'b01, 1'b1)));
        end
        check("throughput_stalls", 32'(stall_cycles), 32'd0);
        drain("drain_tput");

        // Reset with two beats in flight: both must vanish
        out_ready = 1'b0;
        send(16'hAAAA, 3, 2'b00, 1'b1, mk_exp(16'hAAAA, 3, 2'b00, 1'b1, 16'h5555));
        send(16'h5555, 3, 2'b00, 1'b1, mk_exp(16'h5555, 3, 2'b00, 1'b1, 16'hAAAA));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("no_stale_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Sweep every op, amount and direction with random data under random back-pressure
        fork
            begin
                for (int op = 0; op < 4; op++) begin
                    for (int k = 0; k < W; k++) begin
                        for (int l = 0; l < 2; l++) begin
                            logic [W-1:0] d;
                            d = W'($urandom);
                            send(d, k, 2'(op), 1'(l),
                                 mk_exp(d, k, 2'(op), 1'(l), ref_shift(d, k, 2'(op), 1'(l))));
                        end
                    end
                end
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_sweep");

`ifdef BARREL_SHIFTER_FLAGS_EN
        begin
            exp_t e;
            e.data = 16'h0000; e.zero = 1'b1; e.carry = 1'b1;
            send(16'h8000, 1, 2'b01, 1'b1, e);
            e.data = 16'h8000; e.zero = 1'b0; e.carry = 1'b1;
            send(16'h0001, 1, 2'b00, 1'b0, e);
            drain("drain_flags");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the 16-bit combinational rotator. It performs rotate, logical shift and arithmetic shift in both directions on a WIDTH-bit word, using log2(WIDTH) mux levels. A pipeline register follows every PIPE_EVERY levels, and every register carries a valid/ready handshake. It sits in the CPU execute path between the operand mux and the writeback buffer, and it tolerates writeback back-pressure.

Parameters:
WIDTH, 16, data width; must be a power of two and at least 4.
PIPE_EVERY, 2, number of mux levels per pipeline register; must be between 1 and log2(WIDTH).
SHAMT_W, log2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  in  1  single clock; all state is updated on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat this cycle.
in_data  in  WIDTH  operand.
in_shamt  in  SHAMT_W  shift or rotate amount, 0..WIDTH-1.
in_op  in  2  operation: 00 rotate, 01 logical shift, 10 arithmetic shift, 11 pass-through.
in_left  in  1  1 = left, 0 = right.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  WIDTH  result.

Behaviour:
- LEVELS = log2(WIDTH). Level k shifts by 2^k when in_shamt[k] is 1; levels are applied LSB first.
- LAT = ceil(LEVELS/PIPE_EVERY) register stages. The last stage always drives out_data and out_valid directly from a register. Latency is exactly LAT cycles from the accept edge to out_valid when there is no stall (WIDTH=16 with defaults gives LAT=2).
- Each stage holds valid[i], data, and the remaining shamt, op and left bits.
- stage_ready[i] = !valid[i] || stage_ready[i+1], with stage_ready[LAT] = out_ready. in_ready = stage_ready[0].
- The out_ready to in_ready path is combinational; this is accepted and must be documented at integration.
- A stage loads when its stage_ready is 1. A stage with stage_ready 0 holds its contents, including data.
- A beat is accepted only on an edge where in_valid and in_ready are both 1. Results emerge in order, with no drop and no duplicate.
- Rotate: bits wrap around, so left by k equals right by WIDTH-k.
- Logical shift: vacated bits are filled with 0.
- Arithmetic right shift: vacated bits are filled with the original in_data[WIDTH-1], which is captured at accept and carried down the pipe. Arithmetic left shift is identical to logical left.
- Pass-through (op 11) ignores shamt and in_left; data passes through with the same latency.
- in_shamt = 0 returns in_data unchanged for every op.
- Reset values: all valid[i] = 0, out_valid = 0, out_data = 0, and in_ready = 1 in the cycle after reset.
- Reset mid-operation: all in-flight beats are discarded and none appears on the output. Data registers may be cleared or left as they are, but out_data must read 0 while out_valid is 0 after reset.
- Simultaneous accept and drain with a full pipe: when out_ready is 1, every stage advances and the pipe sustains one beat per cycle.
- in_data, in_shamt, in_op and in_left are don't-care when in_valid is 0.

Optional Feature:
Macro BARREL_SHIFTER_FLAGS_EN. When defined, two extra outputs are added, aligned with out_data:
- out_zero (1 bit): 1 when out_data == 0.
- out_carry (1 bit): for shift and rotate with amount k>0, this is the last bit shifted out of the original operand, in_data[WIDTH-k] for left and in_data[k-1] for right. It is 0 when k = 0 and for pass-through.
Both are registered in the final stage and reset to 0. When the macro is not defined, these ports and their logic do not exist.

Decomposition:
- Package shifter_pkg holds the op encoding constants (OP_ROT, OP_LSH, OP_ASH, OP_PASS), the op_t typedef, and a function that computes LAT from WIDTH and PIPE_EVERY.
- Sub-module barrel_level (parameters WIDTH and DIST) implements one mux level: rotate, fill-zero or fill-sign by DIST in either direction, enabled by one shamt bit. It is purely combinational and is instantiated LEVELS times by a generate loop.

Test Plan (WIDTH=16, PIPE_EVERY=2, LAT=2):
- Rotate left 0x8001 by 1 (out_ready=1) -> out_data 0x0003 with out_valid high exactly 2 cycles after accept. Rotate right 0x1234 by 8 -> 0x3412; rotate left by 8 also gives 0x3412.
- Arithmetic right 0x8000 by 4 -> 0xF800. Logical right 0x8000 by 4 -> 0x0800. Logical left 0x00FF by 12 -> 0xF000. Pass-through 0xBEEF with shamt 5 -> 0xBEEF.
- Back-pressure: hold out_ready=0 and offer 4 back-to-back beats A,B,C,D. in_ready falls after 2 accepts. Release out_ready and the outputs are A, B, then C, D, in order with none lost. With out_ready=1 throughout, a full pipe gives 1 result per cycle.
- Reset mid-operation: accept 2 beats, assert rst for 1 cycle -> out_valid=0, out_data=0, in_ready=1 next cycle, and no stale result ever appears.
- Sweep all shamt values 0..15 and all 4 ops on random data against a reference model; shamt 0 returns the input unchanged.
- With the flags macro: logical left 0x8000 by 1 -> out_data 0x0000, out_zero 1, out_carry 1. Rotate right 0x0001 by 1 -> 0x8000, out_zero 0, out_carry 1.
